// File: rtl/lcd_hotspot_rx_pkg.sv
// Shared constants for the LCD hotspot receiver: FSM encodings, RGB565 field layout,
// default panel geometry and the sync polarities used by the thd_show transmitter.
package lcd_hotspot_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_LSB = 0;

  localparam int          DEF_CW       = 16;
  localparam int          DEF_H_ACTIVE = 480;
  localparam int          DEF_V_ACTIVE = 272;
  localparam logic [15:0] DEF_KEY_RGB  = 16'hF800;

  localparam logic HS_ACTIVE = 1'b0;
  localparam logic VS_ACTIVE = 1'b0;
  localparam logic DE_ACTIVE = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } lcd_ctl_t;

  // Field-wise compare so a future tolerance per colour channel has an obvious home.
  function automatic logic rgb565_match(input logic [15:0] a, input logic [15:0] b);
    return (a[15:RGB_R_LSB] == b[15:RGB_R_LSB]) &&
           (a[RGB_R_LSB-1:RGB_G_LSB] == b[RGB_R_LSB-1:RGB_G_LSB]) &&
           (a[RGB_G_LSB-1:RGB_B_LSB] == b[RGB_G_LSB-1:RGB_B_LSB]);
  endfunction

endpackage

// File: rtl/lcd_hotspot_rx_sync_edge.sv
// Two-stage input register for the LCD sync lines plus edge detection between stages;
// pixel data is delayed one stage so it stays aligned with the first-stage sync values.
module lcd_hotspot_rx_sync_edge
  import lcd_hotspot_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [15:0] rgb_i,
  output logic        vs_s1_o,
  output logic        de_s1_o,
  output logic [15:0] rgb_s1_o,
  output logic        hs_fall_o,
  output logic        vs_fall_o,
  output logic        de_fall_o,
  output logic        de_rise_o
);

  // Reset to the idle bus levels so releasing reset never fabricates an edge.
  localparam lcd_ctl_t CTL_IDLE = '{hs: ~HS_ACTIVE, vs: ~VS_ACTIVE, de: ~DE_ACTIVE};

  lcd_ctl_t    s1_q;
  lcd_ctl_t    s2_q;
  logic [15:0] rgb_s1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= CTL_IDLE;
      s2_q <= CTL_IDLE;
    end else begin
      s1_q <= '{hs: hs_i, vs: vs_i, de: de_i};
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    rgb_s1_q <= rgb_i;
  end

  assign vs_s1_o   = s1_q.vs;
  assign de_s1_o   = s1_q.de;
  assign rgb_s1_o  = rgb_s1_q;
  assign hs_fall_o = (s1_q.hs == HS_ACTIVE) && (s2_q.hs != HS_ACTIVE);
  assign vs_fall_o = (s1_q.vs == VS_ACTIVE) && (s2_q.vs != VS_ACTIVE);
  assign de_rise_o = (s1_q.de == DE_ACTIVE) && (s2_q.de != DE_ACTIVE);
  assign de_fall_o = (s1_q.de != DE_ACTIVE) && (s2_q.de == DE_ACTIVE);

endmodule

// File: rtl/lcd_hotspot_rx.sv
// RGB565 LCD receiver: rebuilds pixel coordinates, reports the key-colour bounding-box
// centre and frame geometry errors once per frame. Macro LCD_RX_PIXCNT_EN adds hot_cnt.
module lcd_hotspot_rx
  import lcd_hotspot_rx_pkg::*;
#(
  parameter int          CW       = DEF_CW,
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter logic [15:0] KEY_RGB  = DEF_KEY_RGB
) (
  input  logic          clk_pix,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          lcd_hs,
  input  logic          lcd_vs,
  input  logic          lcd_de,
  input  logic [15:0]   lcd_rgb,
  output logic [CW-1:0] hot_x,
  output logic [CW-1:0] hot_y,
  output logic          hot_found,
  output logic          geom_err,
  output logic          frame_done
`ifdef LCD_RX_PIXCNT_EN
  ,
  output logic [CW-1:0] hot_cnt
`endif
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_PIX   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_LINES = CW'(V_ACTIVE);

  function automatic logic [CW-1:0] centre(input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    logic [CW:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[CW:1];
  endfunction

  logic        vs_s1, de_s1;
  logic [15:0] rgb_s1;
  logic        hs_fall, vs_fall, de_fall, de_rise;

  lcd_hotspot_rx_sync_edge u_sync (
    .clk_i     (clk_pix),
    .rst_ni    (rst_n),
    .hs_i      (lcd_hs),
    .vs_i      (lcd_vs),
    .de_i      (lcd_de),
    .rgb_i     (lcd_rgb),
    .vs_s1_o   (vs_s1),
    .de_s1_o   (de_s1),
    .rgb_s1_o  (rgb_s1),
    .hs_fall_o (hs_fall),
    .vs_fall_o (vs_fall),
    .de_fall_o (de_fall),
    .de_rise_o (de_rise)
  );

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic          found_q, found_d, err_q, err_d;
  logic          hs_seen_q, hs_seen_d;
  logic [CW-1:0] hot_x_q, hot_x_d, hot_y_q, hot_y_d;
  logic          hot_found_q, hot_found_d, geom_err_q, geom_err_d;
  logic          done_q, done_d;
  logic          clr;
`ifdef LCD_RX_PIXCNT_EN
  logic [CW-1:0] cnt_q, cnt_d, hot_cnt_q, hot_cnt_d;
`endif

  logic pix_vld, key_hit, de_in_vs;

  assign pix_vld  = (de_s1 == DE_ACTIVE);
  assign key_hit  = pix_vld && rgb565_match(rgb_s1, KEY_RGB);
  assign de_in_vs = pix_vld && (vs_s1 == VS_ACTIVE);

  // HS bookkeeping runs in every state so the first line after VS is judged correctly.
  always_comb begin
    hs_seen_d = hs_seen_q;
    if (de_rise) hs_seen_d = 1'b0;
    if (hs_fall) hs_seen_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    found_d     = found_q;
    err_d       = err_q;
    hot_x_d     = hot_x_q;
    hot_y_d     = hot_y_q;
    hot_found_d = hot_found_q;
    geom_err_d  = geom_err_q;
    done_d      = 1'b0;
    clr         = 1'b0;
`ifdef LCD_RX_PIXCNT_EN
    cnt_d       = cnt_q;
    hot_cnt_d   = hot_cnt_q;
`endif
    if (!ena) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vs_fall) begin
            state_d = ST_ACTIVE;
            clr     = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (pix_vld) begin
            if (x_q == CNT_MAX) err_d = 1'b1;
            else                x_d   = x_q + 1'b1;
            if (key_hit) begin
              if (x_q < xmin_q) xmin_d = x_q;
              if (x_q > xmax_q) xmax_d = x_q;
              if (y_q < ymin_q) ymin_d = y_q;
              if (y_q > ymax_q) ymax_d = y_q;
              found_d = 1'b1;
`ifdef LCD_RX_PIXCNT_EN
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`endif
            end
          end
          if (de_fall) begin
            if (x_q != H_PIX) err_d = 1'b1;
            x_d = '0;
            if (y_q == CNT_MAX) err_d = 1'b1;
            else                y_d   = y_q + 1'b1;
          end
          if ((de_rise && !hs_seen_q) || de_in_vs) err_d = 1'b1;
          if (vs_fall) state_d = ST_REPORT;
        end
        ST_REPORT: begin
          hot_found_d = found_q;
          hot_x_d     = found_q ? centre(xmin_q, xmax_q) : '0;
          hot_y_d     = found_q ? centre(ymin_q, ymax_q) : '0;
          geom_err_d  = err_q || (y_q != V_LINES);
`ifdef LCD_RX_PIXCNT_EN
          hot_cnt_d   = cnt_q;
`endif
          done_d      = 1'b1;
          clr         = 1'b1;
          state_d     = ST_ACTIVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clr) begin
      x_d     = '0;
      y_d     = '0;
      xmin_d  = CNT_MAX;
      xmax_d  = '0;
      ymin_d  = CNT_MAX;
      ymax_d  = '0;
      found_d = 1'b0;
      err_d   = de_in_vs;
`ifdef LCD_RX_PIXCNT_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      xmin_q      <= CNT_MAX;
      xmax_q      <= '0;
      ymin_q      <= CNT_MAX;
      ymax_q      <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      hs_seen_q   <= 1'b0;
      hot_x_q     <= '0;
      hot_y_q     <= '0;
      hot_found_q <= 1'b0;
      geom_err_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef LCD_RX_PIXCNT_EN
      cnt_q       <= '0;
      hot_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      found_q     <= found_d;
      err_q       <= err_d;
      hs_seen_q   <= hs_seen_d;
      hot_x_q     <= hot_x_d;
      hot_y_q     <= hot_y_d;
      hot_found_q <= hot_found_d;
      geom_err_q  <= geom_err_d;
      done_q      <= done_d;
`ifdef LCD_RX_PIXCNT_EN
      cnt_q       <= cnt_d;
      hot_cnt_q   <= hot_cnt_d;
`endif
    end
  end

  assign hot_x      = hot_x_q;
  assign hot_y      = hot_y_q;
  assign hot_found  = hot_found_q;
  assign geom_err   = geom_err_q;
  assign frame_done = done_q;
`ifdef LCD_RX_PIXCNT_EN
  assign hot_cnt    = hot_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_hotspot_rx.sv
// Frame-level bench for lcd_hotspot_rx at 16x8 geometry: table of frames plus reset/enable
// sequences; each report is predicted when the next VS is driven and checked on frame_done.
module tb_lcd_hotspot_rx;

  localparam logic [15:0] KEY   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ena     = 1'b1;
  logic        lcd_hs  = 1'b1;
  logic        lcd_vs  = 1'b1;
  logic        lcd_de  = 1'b0;
  logic [15:0] lcd_rgb = 16'h0;
  logic [15:0] hot_x, hot_y;
  logic        hot_found, geom_err, frame_done;
`ifdef LCD_RX_PIXCNT_EN
  logic [15:0] hot_cnt;
`endif

  lcd_hotspot_rx #(.CW(16), .H_ACTIVE(16), .V_ACTIVE(8), .KEY_RGB(KEY)) dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .ena        (ena),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .hot_x      (hot_x),
    .hot_y      (hot_y),
    .hot_found  (hot_found),
    .geom_err   (geom_err),
    .frame_done (frame_done)
`ifdef LCD_RX_PIXCNT_EN
    ,
    .hot_cnt    (hot_cnt)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    int x0, x1, y0, y1;
    int short_line;
    int nlines;
    bit de_in_vs;
    int hs_miss;
    int ex, ey, ef, ee, ec;
  } frame_t;

  typedef struct {
    int     ex, ey, ef, ee, ec;
    longint due;
  } exp_t;

  exp_t   expq[$];
  exp_t   prev_exp, last_exp, mon_e;
  bit     armed = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  frame_t tbl[10];

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic frame_t mk(int x0, int x1, int y0, int y1, int sl, int nl, bit dv, int hm,
                                int ex, int ey, int ef, int ee, int ec);
    frame_t f;
    f.x0 = x0; f.x1 = x1; f.y0 = y0; f.y1 = y1;
    f.short_line = sl; f.nlines = nl; f.de_in_vs = dv; f.hs_miss = hm;
    f.ex = ex; f.ey = ey; f.ef = ef; f.ee = ee; f.ec = ec;
    return f;
  endfunction

  always @(negedge clk_pix) begin
    if (rst_n && frame_done) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("hot_x", hot_x, mon_e.ex);
        chk("hot_y", hot_y, mon_e.ey);
        chk("hot_found", hot_found, mon_e.ef);
        chk("geom_err", geom_err, mon_e.ee);
        chk("frame_done_cycle", cyc, mon_e.due);
`ifdef LCD_RX_PIXCNT_EN
        chk("hot_cnt", hot_cnt, mon_e.ec);
`endif
        last_exp = mon_e;
      end
    end
  end

  // One 22-cycle line: HS low for 2, back porch 2, nde DE pixels, remaining blanking.
  task automatic line(input bit vs, input int nde, input bit hs_en, input int y, input frame_t f);
    int px;
    for (int c = 0; c < 22; c++) begin
      px      = c - 4;
      lcd_vs  = vs;
      lcd_hs  = !(hs_en && c < 2);
      lcd_de  = (c >= 4) && (c < 4 + nde);
      lcd_rgb = !lcd_de ? 16'h0 :
                (y >= f.y0 && y <= f.y1 && px >= f.x0 && px <= f.x1) ? KEY : GREEN;
      @(posedge clk_pix);
      #1;
    end
  endtask

  task automatic send_frame(input frame_t f, input int rst_line, input int ena_line);
    if (armed) begin
      prev_exp.due = cyc + 3;
      expq.push_back(prev_exp);
    end
    armed = 1'b1;
    line(1'b0, f.de_in_vs ? 4 : 0, 1'b1, -1, f);
    line(1'b0, 0, 1'b1, -1, f);
    line(1'b1, 0, 1'b1, -1, f);
    for (int y = 0; y < f.nlines; y++) begin
      if (y == rst_line) begin
        rst_n = 1'b0;
        #1;
        chk("rst_hot_x", hot_x, 0);
        chk("rst_hot_y", hot_y, 0);
        chk("rst_hot_found", hot_found, 0);
        chk("rst_geom_err", geom_err, 0);
        @(posedge clk_pix);
        #1;
        rst_n    = 1'b1;
        armed    = 1'b0;
        last_exp = '{0, 0, 0, 0, 0, 0};
      end
      if (y == ena_line) begin
        ena = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        ena   = 1'b1;
        armed = 1'b0;
        chk("hold_hot_x", hot_x, last_exp.ex);
        chk("hold_hot_y", hot_y, last_exp.ey);
        chk("hold_hot_found", hot_found, last_exp.ef);
        chk("hold_geom_err", geom_err, last_exp.ee);
      end
      line(1'b1, (y == f.short_line) ? 15 : 16, y != f.hs_miss, y, f);
    end
    line(1'b1, 0, 1'b1, -1, f);
    prev_exp = '{f.ex, f.ey, f.ef, f.ee, f.ec, 0};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk( 5,  5,  3,  3, -1, 8, 0, -1,  5, 3, 1, 0,   1);
    tbl[1] = mk( 4,  9,  2,  6, -1, 8, 0, -1,  6, 4, 1, 0,  30);
    tbl[2] = mk(-1, -1, -1, -1, -1, 8, 0, -1,  0, 0, 0, 0,   0);
    tbl[3] = mk( 5,  5,  3,  3,  4, 8, 0, -1,  5, 3, 1, 1,   1);
    tbl[4] = mk( 0, 15,  0,  7, -1, 8, 0, -1,  7, 3, 1, 0, 128);
    tbl[5] = mk(10, 12,  5,  7, -1, 8, 0, -1, 11, 6, 1, 0,   9);
    tbl[6] = mk(-1, -1, -1, -1, -1, 9, 0, -1,  0, 0, 0, 1,   0);
    tbl[7] = mk(-1, -1, -1, -1, -1, 8, 1, -1,  0, 0, 0, 1,   0);
    tbl[8] = mk(-1, -1, -1, -1, -1, 8, 0,  2,  0, 0, 0, 1,   0);
    tbl[9] = mk(15, 15,  7,  7, -1, 8, 0, -1, 15, 7, 1, 0,   1);

    repeat (3) @(posedge clk_pix);
    #1;
    chk("reset_hot_x", hot_x, 0);
    chk("reset_hot_y", hot_y, 0);
    chk("reset_hot_found", hot_found, 0);
    chk("reset_geom_err", geom_err, 0);
    chk("reset_frame_done", frame_done, 0);
`ifdef LCD_RX_PIXCNT_EN
    chk("reset_hot_cnt", hot_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1;

    for (int i = 0; i < 10; i++) send_frame(tbl[i], -1, -1);

    // Reset mid-frame, then a discarded partial frame and a correctly reported one.
    send_frame(mk(5, 5, 3, 3, -1, 8, 0, -1, 5, 3, 1, 0, 1), 3, -1);
    send_frame(mk(10, 12, 5, 7, -1, 8, 0, -1, 11, 6, 1, 0, 9), -1, -1);
    send_frame(mk(4, 9, 2, 6, -1, 8, 0, -1, 6, 4, 1, 0, 30), -1, -1);

    // Enable dropped mid-frame: no report for that frame, outputs hold, restart on fresh VS.
    send_frame(mk(0, 15, 0, 7, -1, 8, 0, -1, 7, 3, 1, 0, 128), -1, 2);
    send_frame(mk(5, 5, 3, 3, -1, 8, 0, -1, 5, 3, 1, 0, 1), -1, -1);
    send_frame(mk(-1, -1, -1, -1, -1, 0, 0, -1, 0, 0, 0, 1, 0), -1, -1);

    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk_pix);
    #1;
    chk("reports_outstanding", expq.size(), 0);
    repeat (5) @(posedge clk_pix);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
